// File: rtl/latch_bank_if.sv
// -----------------------------------------------------------------------------
// latch_bank_if
//   Bundle between two write requesters and the latch bank controller.
//
//   Requester side (master) drives:
//     req[1:0]      write request per requester, held until its ack
//     addr0, addr1  target latch index per requester
//     data0, data1  write data per requester
//     clr           request to reset every latch in the bank
//   Controller side (slave) drives:
//     ack[1:0]      one-cycle completion pulse per requester
//     busy          controller is not idle
//     lat_d         shared data bus to all latch d inputs
//     lat_en        per-latch enable, one-hot or all-zero
//     lat_rstn      shared active-low latch reset
// -----------------------------------------------------------------------------
interface latch_bank_if #(
  parameter int W    = 8,
  parameter int NLAT = 4
);
  localparam int AW = $clog2(NLAT);

  logic [1:0]      req;
  logic [AW-1:0]   addr0;
  logic [AW-1:0]   addr1;
  logic [W-1:0]    data0;
  logic [W-1:0]    data1;
  logic            clr;

  logic [1:0]      ack;
  logic            busy;
  logic [W-1:0]    lat_d;
  logic [NLAT-1:0] lat_en;
  logic            lat_rstn;

  modport master (
    output req, addr0, addr1, data0, data1, clr,
    input  ack, busy, lat_d, lat_en, lat_rstn
  );

  modport slave (
    input  req, addr0, addr1, data0, data1, clr,
    output ack, busy, lat_d, lat_en, lat_rstn
  );
endinterface

// File: rtl/latch_bank_ctrl.sv
// -----------------------------------------------------------------------------
// latch_bank_ctrl
//   Writes a bank of NLAT level-sensitive latches on behalf of two requesters.
//   A write walks SETUP (data bus settles) -> OPEN (one enable high for
//   OPEN_CYC cycles) -> HOLD (enable closed, data still stable) -> ACK, so the
//   latch data input never moves while its enable is open. A bank clear drives
//   the shared latch reset low for two cycles. Every output is a flop.
//
//   Ports:
//     clk   in   single clock, rising edge
//     rst   in   synchronous active-high reset
//     bus   slave modport of latch_bank_if (requests in, latch controls out)
//
//   Parameters:
//     W         data width of each latch
//     NLAT      latches in the bank (power of two, >= 2)
//     OPEN_CYC  cycles the selected enable stays open (>= 1)
// -----------------------------------------------------------------------------
module latch_bank_ctrl #(
  parameter int W        = 8,
  parameter int NLAT     = 4,
  parameter int OPEN_CYC = 2
) (
  input logic         clk,
  input logic         rst,
  latch_bank_if.slave bus
);

  localparam int AW = $clog2(NLAT);
  // One counter serves both the 2-cycle CLEAR and the OPEN_CYC-cycle OPEN.
  localparam int CW = ($clog2(OPEN_CYC) > 0) ? $clog2(OPEN_CYC) : 1;
  localparam logic [CW-1:0] open_last  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] clear_last = CW'(1);
  localparam logic [NLAT-1:0] en_one   = NLAT'(1);

  // State encoding kept as plain constants for compatibility with older tools.
  localparam logic [2:0] st_clear = 3'd0;
  localparam logic [2:0] st_idle  = 3'd1;
  localparam logic [2:0] st_setup = 3'd2;
  localparam logic [2:0] st_open  = 3'd3;
  localparam logic [2:0] st_hold  = 3'd4;
  localparam logic [2:0] st_ack   = 3'd5;

  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic            ptr;        // requester favoured when both request
  logic            gnt;        // requester owning the write in flight
  logic            clr_pend;   // clear seen outside IDLE, served at next IDLE
  logic [AW-1:0]   cap_addr;

  logic [1:0]      ack_q;
  logic            busy_q;
  logic [W-1:0]    lat_d_q;
  logic [NLAT-1:0] lat_en_q;
  logic            lat_rstn_q;

  logic            gnt_c;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer.
  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    gnt_c = 1'b0;
    if (bus.req == 2'b11) gnt_c = ptr;
    else if (bus.req[1])  gnt_c = 1'b1;
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= st_clear;
      cnt        <= '0;
      ptr        <= 1'b0;
      gnt        <= 1'b0;
      clr_pend   <= 1'b0;
      cap_addr   <= '0;
      ack_q      <= 2'b00;
      busy_q     <= 1'b1;
      lat_d_q    <= '0;
      lat_en_q   <= '0;
      lat_rstn_q <= 1'b0;
    end else begin
      ack_q <= 2'b00;

      // Clears arriving while busy collapse into one pending clear.
      if (bus.clr && (state != st_idle)) clr_pend <= 1'b1;

      case (state)
        st_clear: begin
          if (cnt == clear_last) begin
            state      <= st_idle;
            lat_rstn_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        st_idle: begin
          if (bus.clr || clr_pend) begin
            state      <= st_clear;
            clr_pend   <= 1'b0;
            cnt        <= '0;
            lat_rstn_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (bus.req != 2'b00) begin
            // Capture now; the inputs are ignored until the write is acked.
            state    <= st_setup;
            busy_q   <= 1'b1;
            gnt      <= gnt_c;
            ptr      <= ~gnt_c;
            cap_addr <= gnt_c ? bus.addr1 : bus.addr0;
            lat_d_q  <= gnt_c ? bus.data1 : bus.data0;
          end
        end

        st_setup: begin
          state    <= st_open;
          cnt      <= '0;
          lat_en_q <= en_one << cap_addr;
        end

        st_open: begin
          if (cnt == open_last) begin
            state    <= st_hold;
            lat_en_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        st_hold: begin
          state <= st_ack;
          ack_q <= gnt ? 2'b10 : 2'b01;
        end

        st_ack: begin
          state  <= st_idle;
          busy_q <= 1'b0;
        end

        default: begin
          // Unreachable encodings recover through a full bank clear.
          state      <= st_clear;
          cnt        <= '0;
          lat_en_q   <= '0;
          lat_rstn_q <= 1'b0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.lat_d    = lat_d_q;
  assign bus.lat_en   = lat_en_q;
  assign bus.lat_rstn = lat_rstn_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latch_bank_ctrl
//   Directed bench for latch_bank_ctrl with W=8, NLAT=4, OPEN_CYC=2.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_latch_bank_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  latch_bank_if #(.W(8), .NLAT(4)) bus ();

  latch_bank_ctrl #(.W(8), .NLAT(4), .OPEN_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic got;
    logic exp_g;

    rst       = 1'b1;
    bus.req   = 2'b00;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.data0 = '0;
    bus.data1 = '0;
    bus.clr   = 1'b0;

    // ---- reset and release: two CLEAR cycles, then IDLE ----
    tick(); tick(); tick();
    check("rst_lat_rstn", bus.lat_rstn, 0);
    check("rst_busy",     bus.busy,     1);
    check("rst_lat_en",   bus.lat_en,   0);
    check("rst_lat_d",    bus.lat_d,    0);
    check("rst_ack",      bus.ack,      0);
    rst = 1'b0;
    check("clr1_rstn", bus.lat_rstn, 0);
    tick();
    check("clr2_rstn", bus.lat_rstn, 0);
    check("clr2_busy", bus.busy,     1);
    tick();
    check("idle_rstn", bus.lat_rstn, 1);
    check("idle_busy", bus.busy,     0);

    // ---- single write: requester 0, addr 2, data A5 ----
    bus.req = 2'b01; bus.addr0 = 2'd2; bus.data0 = 8'hA5;
    tick();
    check("w1_setup_d",  bus.lat_d,  8'hA5);
    check("w1_setup_en", bus.lat_en, 0);
    check("w1_setup_ack", bus.ack,   0);
    tick();
    check("w1_open1_en", bus.lat_en, 4'b0100);
    tick();
    check("w1_open2_en", bus.lat_en, 4'b0100);
    check("w1_open2_d",  bus.lat_d,  8'hA5);
    tick();
    check("w1_hold_en",  bus.lat_en, 0);
    check("w1_hold_ack", bus.ack,    0);
    tick();
    check("w1_ack",      bus.ack,    2'b01);
    bus.req = 2'b00;
    tick();
    check("w1_idle_ack",  bus.ack,   0);
    check("w1_idle_busy", bus.busy,  0);
    check("w1_idle_d",    bus.lat_d, 8'hA5);

    // ---- stability: inputs change during OPEN ----
    bus.req = 2'b01; bus.addr0 = 2'd3; bus.data0 = 8'h3C;
    tick();
    tick();
    check("st_open1_en", bus.lat_en, 4'b1000);
    bus.addr0 = 2'd0; bus.data0 = 8'hFF;
    tick();
    check("st_open2_en", bus.lat_en, 4'b1000);
    check("st_open2_d",  bus.lat_d,  8'h3C);
    tick();
    tick();
    check("st_ack", bus.ack, 2'b01);
    bus.req = 2'b00;
    tick();

    // ---- clr during OPEN of a write to addr 1 (requester 1) ----
    bus.req = 2'b10; bus.addr1 = 2'd1; bus.data1 = 8'h5A;
    tick();
    check("mc_setup_d", bus.lat_d, 8'h5A);
    tick();
    check("mc_open_en", bus.lat_en, 4'b0010);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("mc_open2_en", bus.lat_en, 4'b0010);
    check("mc_open2_rstn", bus.lat_rstn, 1);
    tick();
    tick();
    check("mc_ack", bus.ack, 2'b10);
    bus.req = 2'b00;
    tick();
    check("mc_idle_busy", bus.busy, 0);
    bus.req = 2'b10; bus.addr1 = 2'd2; bus.data1 = 8'h66;
    tick();
    check("mc_clear1_rstn", bus.lat_rstn, 0);
    check("mc_clear1_busy", bus.busy,     1);
    tick();
    check("mc_clear2_rstn", bus.lat_rstn, 0);
    check("mc_clear2_en",   bus.lat_en,   0);
    tick();
    check("mc_idle2_rstn", bus.lat_rstn, 1);
    check("mc_idle2_busy", bus.busy,     0);
    check("mc_idle2_d",    bus.lat_d,    8'h5A);
    tick();
    check("mc_w_setup_d", bus.lat_d, 8'h66);
    tick();
    check("mc_w_open_en", bus.lat_en, 4'b0100);
    tick(); tick(); tick();
    check("mc_w_ack", bus.ack, 2'b10);
    bus.req = 2'b00;
    tick();

    // ---- contention: both held high, grants alternate 0,1,0,1 ----
    bus.addr0 = 2'd0; bus.data0 = 8'h11;
    bus.addr1 = 2'd3; bus.data1 = 8'h22;
    bus.req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0];
      got   = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        tick();
        check("ct_onehot0", $onehot0(bus.lat_en), 1);
        if (bus.lat_en != 0) begin
          check("ct_en", bus.lat_en, exp_g ? 4'b1000 : 4'b0001);
          check("ct_d",  bus.lat_d,  exp_g ? 8'h22 : 8'h11);
        end
        if (bus.ack != 0) begin
          got = 1'b1;
          check("ct_ack", bus.ack, exp_g ? 2'b10 : 2'b01);
        end
      end
      check("ct_ack_seen", got, 1);
      tick();
      check("ct_ack_single", bus.ack, 0);
    end
    bus.req = 2'b00;
    tick();

    // ---- reset during OPEN aborts the write ----
    bus.req = 2'b01; bus.addr0 = 2'd1; bus.data0 = 8'hC3;
    tick();
    tick();
    check("ra_open_en", bus.lat_en, 4'b0010);
    rst = 1'b1;
    tick();
    check("ra_en",   bus.lat_en,   0);
    check("ra_ack",  bus.ack,      0);
    check("ra_rstn", bus.lat_rstn, 0);
    check("ra_busy", bus.busy,     1);
    check("ra_d",    bus.lat_d,    0);
    rst = 1'b0; bus.req = 2'b00;
    tick();
    check("ra_clear2_rstn", bus.lat_rstn, 0);
    check("ra_clear2_ack",  bus.ack,      0);
    tick();
    check("ra_idle_rstn", bus.lat_rstn, 1);
    check("ra_idle_busy", bus.busy,     0);
    check("ra_idle_ack",  bus.ack,      0);

    // ---- pointer back at 0 after reset: tie goes to requester 0 ----
    bus.data0 = 8'h81; bus.data1 = 8'h42; bus.req = 2'b11;
    tick();
    check("pr_setup_d", bus.lat_d, 8'h81);
    tick(); tick(); tick(); tick();
    check("pr_ack", bus.ack, 2'b01);
    bus.req = 2'b00;
    tick();

    // ---- clr sampled directly in IDLE ----
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("ic_clear_rstn", bus.lat_rstn, 0);
    tick();
    tick();
    check("ic_idle_rstn", bus.lat_rstn, 1);
    check("ic_idle_busy", bus.busy,     0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
